// File: rtl/fb_row_loader.sv
// Double-buffered line buffer between the SPI framebuffer-write stream and the
// panel frame buffer: bursts a stored line out over a valid/ready port.
module fb_row_loader #(
    parameter int N_ROWS     = 64,
    parameter int N_COLS     = 64,
    parameter int LOG_N_ROWS = $clog2(N_ROWS),
    parameter int LOG_N_COLS = $clog2(N_COLS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [LOG_N_ROWS-1:0]            fbw_row_addr,
    input  logic                             fbw_row_store,
    output logic                             fbw_row_rdy,
    input  logic                             fbw_row_swap,
    input  logic [23:0]                      fbw_data,
    input  logic [LOG_N_COLS-1:0]            fbw_col_addr,
    input  logic                             fbw_wren,
    input  logic                             frame_swap,
    output logic                             frame_rdy,
    output logic [LOG_N_ROWS+LOG_N_COLS-1:0] fb_addr,
    output logic [23:0]                      fb_data,
    output logic                             fb_valid,
    input  logic                             fb_ready,
    output logic                             fb_frame_swap,
    input  logic                             fb_frame_done,
    output logic                             err_ovr
);
    typedef enum logic [1:0] {IDLE, PRIME, XFER} state_t;

    state_t                  state_q, state_d;
    logic                    wr_sel_q, wr_sel_d;
    logic [LOG_N_ROWS-1:0]   row_q, row_d;
    logic [LOG_N_COLS-1:0]   col_q, col_d;
    logic                    fb_valid_q, fb_valid_d;
    logic                    frame_rdy_q, frame_rdy_d;
    logic                    pend_q, pend_d;
    logic                    fswap_q, fswap_d;
    logic                    err_q, err_d;

    logic [23:0]             lb0 [N_COLS];
    logic [23:0]             lb1 [N_COLS];
    logic [23:0]             rd_q;
    logic                    rd_en, rd_sel;
    logic [LOG_N_COLS-1:0]   rd_addr;

    logic idle, acc, last_col;
    assign idle     = (state_q == IDLE);
    assign acc      = fb_valid_q & fb_ready;
    assign last_col = (col_q == LOG_N_COLS'(N_COLS - 1));

    always_comb begin
        state_d    = state_q;
        wr_sel_d   = wr_sel_q;
        row_d      = row_q;
        col_d      = col_q;
        fb_valid_d = fb_valid_q;
        rd_en      = 1'b0;
        rd_addr    = col_q;
        rd_sel     = ~wr_sel_q;
        err_d      = err_q | (~idle & (fbw_row_store | fbw_row_swap))
                           | (~frame_rdy_q & frame_swap);
        unique case (state_q)
            IDLE: begin
                if (fbw_row_swap) wr_sel_d = ~wr_sel_q;
                if (fbw_row_store) begin
                    row_d   = fbw_row_addr;
                    col_d   = '0;
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    // A swap in the same cycle makes the just-written side the read side.
                    rd_sel  = fbw_row_swap ? wr_sel_q : ~wr_sel_q;
                    state_d = PRIME;
                end
            end
            PRIME: state_d = XFER;
            XFER: begin
                if (!fb_valid_q) begin
                    fb_valid_d = 1'b1;
                end else if (acc) begin
                    if (last_col) begin
                        fb_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        col_d   = col_q + 1'b1;
                        rd_en   = 1'b1;
                        rd_addr = col_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame swap handshake: deferred while a row copy is in flight.
    always_comb begin
        frame_rdy_d = frame_rdy_q;
        pend_d      = pend_q;
        fswap_d     = 1'b0;
        if (frame_swap && frame_rdy_q) begin
            frame_rdy_d = 1'b0;
            if (idle && !fbw_row_store) fswap_d = 1'b1;
            else                        pend_d  = 1'b1;
        end else if (pend_q && idle) begin
            fswap_d = 1'b1;
            pend_d  = 1'b0;
        end else if (fb_frame_done && !frame_rdy_q && !pend_q) begin
            frame_rdy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_sel_q    <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            fb_valid_q  <= 1'b0;
            frame_rdy_q <= 1'b1;
            pend_q      <= 1'b0;
            fswap_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_sel_q    <= wr_sel_d;
            row_q       <= row_d;
            col_q       <= col_d;
            fb_valid_q  <= fb_valid_d;
            frame_rdy_q <= frame_rdy_d;
            pend_q      <= pend_d;
            fswap_q     <= fswap_d;
            err_q       <= err_d;
        end
    end

    // Line buffer storage; read port only advances on accept so fb_data holds under stall.
    always_ff @(posedge clk) begin
        if (fbw_wren) begin
            if (wr_sel_q) lb1[fbw_col_addr] <= fbw_data;
            else          lb0[fbw_col_addr] <= fbw_data;
        end
        if (rd_en) rd_q <= rd_sel ? lb1[rd_addr] : lb0[rd_addr];
    end

    assign fbw_row_rdy   = idle;
    assign frame_rdy     = frame_rdy_q;
    assign fb_addr       = {row_q, col_q};
    assign fb_data       = rd_q;
    assign fb_valid      = fb_valid_q;
    assign fb_frame_swap = fswap_q;
    assign err_ovr       = err_q;
endmodule

// File: doc/fb_row_loader.md
Name: fb_row_loader

Overview:
- Sits directly downstream of the SPI video-stream front end.
- Consumes its framebuffer-write stream: per-column pixel writes, row store, row swap and frame swap.
- Holds a double-buffered line buffer. On row store, bursts the completed line into the panel frame buffer over a valid/ready write port.
- Reports row and frame readiness back upstream for the host status byte.

Parameters:
- N_ROWS, 64, panel rows (power of 2).
- N_COLS, 64, panel columns (power of 2).
- LOG_N_ROWS, $clog2(N_ROWS), row address width.
- LOG_N_COLS, $clog2(N_COLS), column address width.

Ports:
- clk  in  1  single block clock.
- rst_n  in  1  asynchronous active-low reset.
- fbw_row_addr  in  LOG_N_ROWS  target frame-buffer row, sampled on fbw_row_store.
- fbw_row_store  in  1  pulse: copy read-side line buffer to row fbw_row_addr.
- fbw_row_rdy  out  1  high when no copy is active and a store or swap is accepted.
- fbw_row_swap  in  1  pulse: exchange write-side and read-side line buffers.
- fbw_data  in  24  pixel data.
- fbw_col_addr  in  LOG_N_COLS  pixel column.
- fbw_wren  in  1  write fbw_data at fbw_col_addr into the write-side line buffer.
- frame_swap  in  1  pulse: request a frame buffer swap.
- frame_rdy  out  1  high when a frame swap is accepted.
- fb_addr  out  LOG_N_ROWS+LOG_N_COLS  {row, col} frame-buffer address.
- fb_data  out  24  pixel to frame buffer.
- fb_valid  out  1  fb_addr/fb_data valid.
- fb_ready  in  1  frame buffer accepts the word when fb_valid & fb_ready.
- fb_frame_swap  out  1  one-cycle swap command to the display side.
- fb_frame_done  in  1  pulse: display has completed the swap.
- err_ovr  out  1  sticky: a command was dropped due to a protocol violation.

Behaviour:
- Reset (rst_n low, async): fb_valid=0, fb_frame_swap=0, err_ovr=0, fbw_row_rdy=1, frame_rdy=1, wr_sel=0, FSM=IDLE, no pending frame swap. Assertion mid-copy aborts the copy; fb_valid drops immediately. Line buffer contents are undefined after reset.
- Line buffers: LB0/LB1, N_COLS x 24 each, 1-cycle synchronous read. fbw_wren writes LB[wr_sel][fbw_col_addr] at the clock edge. Writes are accepted in every state, including during a copy (they go to the write side, so there is no conflict).
- fbw_row_swap accepted only in IDLE: wr_sel toggles at the edge.
- Same cycle swap + store: swap first. The copy reads the newly toggled read side, i.e. the line just written.
- FSM IDLE:
  - fbw_row_store latches row=fbw_row_addr and col=0.
  - Issues a read of LB[~wr_sel][0] and goes to PRIME.
  - fbw_row_rdy falls at the same edge.
- FSM PRIME: read data lands. fb_valid rises at the next edge. Go to XFER.
- FSM XFER:
  - fb_data is the RAM output; fb_addr={row,col}.
  - On fb_valid&fb_ready: if col==N_COLS-1, fb_valid=0, FSM=IDLE, fbw_row_rdy=1 at that edge. Otherwise col+1 and read the next column.
  - RAM read enable is gated by accept, so the output holds while fb_ready is low.
  - Sustains 1 word/cycle when fb_ready is held high.
- Latency: store at edge t -> fb_valid at t+2. With fb_ready always high, fbw_row_rdy returns at t+2+N_COLS.
- Store or swap while not IDLE: ignored, err_ovr set.
- frame_swap when frame_rdy=1: frame_rdy falls next edge.
  - If IDLE: fb_frame_swap pulses 1 cycle at the next edge.
  - If copying: the request is held pending. fb_frame_swap pulses the cycle after the copy returns to IDLE, so the last row lands before the swap.
- frame_rdy rises the edge after fb_frame_done. fb_frame_done when not waiting is ignored.
- frame_swap while frame_rdy=0: ignored, err_ovr set.
- Column counter is LOG_N_COLS wide and terminates at N_COLS-1; it never wraps into the next row.

Test Plan:
- Reset release, write cols 0..63 with data 0x010000+col, swap, store row 5, fb_ready=1 -> 64 words, addr {5,c}, data 0x010000+c; fb_valid 2 cycles after store; fbw_row_rdy low for exactly 66 cycles.
- Same fill, store with fb_ready toggling 1-0 every cycle -> same 64 words in order, no duplicates or drops, data stable while fb_ready=0.
- Swap+store in one cycle after filling LB0 with 0xAAAAAA -> copy emits 0xAAAAAA; writes of 0x555555 during the copy land in LB1, verified by a second swap+store to row 6.
- Store issued mid-copy -> ignored, err_ovr=1, the original copy completes unchanged.
- frame_swap during copy of row 63 -> fb_frame_swap is exactly one pulse, one cycle after the last accept; frame_rdy stays low until fb_frame_done, then rises next edge; a second frame_swap while low sets err_ovr.
- rst_n low at word 10 of a copy -> fb_valid=0 immediately; after release fbw_row_rdy=1 and frame_rdy=1; a new store of row 2 completes normally.
